// File: rtl/pcpi_pkg.sv
// Shared decode constants and FSM encoding for the PCPI M-extension scheduler.
package pcpi_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

endpackage

// File: rtl/pcpi_sat_cnt.sv
// Saturating event counter; clear takes precedence over increment.
module pcpi_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pcpi_sched.sv
// Arbiter between the PicoRV32 PCPI port and the multiplier/divider wrappers,
// with a per-grant cycle limit, completion counters and a sticky timeout flag.
module pcpi_sched
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pcpi_valid,
    input  logic [31:0]      pcpi_insn,
    output logic             pcpi_wr,
    output logic [31:0]      pcpi_rd,
    output logic             pcpi_wait,
    output logic             pcpi_ready,
    output logic             mul_valid,
    input  logic             mul_wr,
    input  logic [31:0]      mul_rd,
    input  logic             mul_ready,
    output logic             div_valid,
    input  logic             div_wr,
    input  logic [31:0]      div_rd,
    input  logic             div_ready,
    input  logic             cfg_mul_en,
    input  logic             cfg_div_en,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_mul_cnt,
    output logic [CNT_W-1:0] stat_div_cnt,
    output logic             stat_timeout
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_timer;
    logic       r_timeout;
    logic       w_match;
    logic       w_is_div;
    logic       w_tlast;
    logic       w_mul_inc;
    logic       w_div_inc;
    logic       w_to_set;
    logic       w_unused_insn;

    assign w_match  = (pcpi_insn[6:0] == OPC_OP) &&
                      (pcpi_insn[31:25] == F7_MULDIV);
    assign w_is_div = pcpi_insn[14];
    assign w_tlast  = (r_timer == TO_LAST);
    assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[13:7]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timer reads 0 in the first grant cycle and counts grant cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
            r_timer <= r_timer + 8'd1;
        end else begin
            r_timer <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timeout <= 1'b0;
        end else if (w_to_set) begin
            r_timeout <= 1'b1;
        end else if (stat_clr) begin
            r_timeout <= 1'b0;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mul_inc  = 1'b0;
        w_div_inc  = 1'b0;
        w_to_set   = 1'b0;
        mul_valid  = 1'b0;
        div_valid  = 1'b0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (pcpi_valid && w_match) begin
                    if (!w_is_div && cfg_mul_en) begin
                        w_next = S_MUL;
                    end else if (w_is_div && cfg_div_en) begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL: begin
                mul_valid  = pcpi_valid;
                pcpi_wait  = 1'b1;
                pcpi_ready = mul_ready;
                pcpi_wr    = mul_ready & mul_wr;
                pcpi_rd    = mul_ready ? mul_rd : '0;
                if (mul_ready) begin
                    w_next    = S_DONE;
                    w_mul_inc = 1'b1;
                end else if (w_tlast) begin
                    w_next   = S_ABORT;
                    w_to_set = 1'b1;
                end else if (!pcpi_valid) begin
                    w_next = S_IDLE;
                end
            end
            S_DIV: begin
                div_valid  = pcpi_valid;
                pcpi_wait  = 1'b1;
                pcpi_ready = div_ready;
                pcpi_wr    = div_ready & div_wr;
                pcpi_rd    = div_ready ? div_rd : '0;
                if (div_ready) begin
                    w_next    = S_DONE;
                    w_div_inc = 1'b1;
                end else if (w_tlast) begin
                    w_next   = S_ABORT;
                    w_to_set = 1'b1;
                end else if (!pcpi_valid) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            // Wait is dropped so the core's own timeout traps the insn.
            S_ABORT: begin
                if (!pcpi_valid) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    pcpi_sat_cnt #(.W(CNT_W)) u_mul_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (stat_clr),
        .i_inc  (w_mul_inc),
        .o_cnt  (stat_mul_cnt)
    );

    pcpi_sat_cnt #(.W(CNT_W)) u_div_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (stat_clr),
        .i_inc  (w_div_inc),
        .o_cnt  (stat_div_cnt)
    );

    assign stat_timeout = r_timeout;

endmodule

// File: tb/tb_pcpi_sched.sv
// Randomized scenario bench for pcpi_sched (TIMEOUT=8, CNT_W=2).
module tb_pcpi_sched;

    localparam int TO   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pcpi_valid = 1'b0;
    logic [31:0]   pcpi_insn = '0;
    logic          pcpi_wr;
    logic [31:0]   pcpi_rd;
    logic          pcpi_wait;
    logic          pcpi_ready;
    logic          mul_valid;
    logic          mul_wr = 1'b0;
    logic [31:0]   mul_rd = '0;
    logic          mul_ready = 1'b0;
    logic          div_valid;
    logic          div_wr = 1'b0;
    logic [31:0]   div_rd = '0;
    logic          div_ready = 1'b0;
    logic          cfg_mul_en = 1'b1;
    logic          cfg_div_en = 1'b1;
    logic          stat_clr = 1'b0;
    logic [CW-1:0] stat_mul_cnt;
    logic [CW-1:0] stat_div_cnt;
    logic          stat_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    // Model: completions since last clear and expected sticky flag.
    int n_mul = 0;
    int n_div = 0;
    bit exp_to = 1'b0;

    always #5 clk = ~clk;

    pcpi_sched #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_wr      (pcpi_wr),
        .pcpi_rd      (pcpi_rd),
        .pcpi_wait    (pcpi_wait),
        .pcpi_ready   (pcpi_ready),
        .mul_valid    (mul_valid),
        .mul_wr       (mul_wr),
        .mul_rd       (mul_rd),
        .mul_ready    (mul_ready),
        .div_valid    (div_valid),
        .div_wr       (div_wr),
        .div_rd       (div_rd),
        .div_ready    (div_ready),
        .cfg_mul_en   (cfg_mul_en),
        .cfg_div_en   (cfg_div_en),
        .stat_clr     (stat_clr),
        .stat_mul_cnt (stat_mul_cnt),
        .stat_div_cnt (stat_div_cnt),
        .stat_timeout (stat_timeout)
    );

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    function automatic logic [31:0] mk_insn(input bit is_div);
        logic [2:0] f3;
        f3 = {is_div, 2'($urandom_range(0, 3))};
        return {7'b0000001, 5'($urandom), 5'($urandom), f3,
                5'($urandom), 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full granted instruction, checked cycle by cycle.
    task automatic run_op(input bit is_div, input int lat,
                          input logic [31:0] rd, input bit wr,
                          input bit clr_at_ready);
        logic uv;
        logic ov;
        cfg_mul_en = 1'b1;
        cfg_div_en = 1'b1;
        pcpi_insn  = mk_insn(is_div);
        pcpi_valid = 1'b1;
        #1;
        uv = is_div ? div_valid : mul_valid;
        n_tests++;
        if (uv !== 1'b0 || pcpi_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL op_issue: valid=%b wait=%b, need 0/0", uv, pcpi_wait);
        end
        tick();
        for (int g = 0; g < lat; g++) begin
            cfg_mul_en = 1'($urandom);
            cfg_div_en = 1'($urandom);
            if (is_div) mul_ready = 1'($urandom);
            else        div_ready = 1'($urandom);
            #1;
            uv = is_div ? div_valid : mul_valid;
            ov = is_div ? mul_valid : div_valid;
            n_tests++;
            if (uv !== 1'b1 || ov !== 1'b0 || pcpi_wait !== 1'b1 ||
                pcpi_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL op_grant g=%0d: uv=%b ov=%b wait=%b rdy=%b, need 1/0/1/0",
                         g, uv, ov, pcpi_wait, pcpi_ready);
            end
            tick();
        end
        if (is_div) begin
            div_ready = 1'b1; div_rd = rd; div_wr = wr;
        end else begin
            mul_ready = 1'b1; mul_rd = rd; mul_wr = wr;
        end
        stat_clr = clr_at_ready;
        #1;
        n_tests++;
        if (pcpi_ready !== 1'b1 || pcpi_wr !== wr || pcpi_rd !== rd) begin
            n_fail++;
            $display("FAIL op_result: rdy=%b wr=%b rd=%h, need 1/%b/%h",
                     pcpi_ready, pcpi_wr, pcpi_rd, wr, rd);
        end
        if (clr_at_ready) begin
            n_mul = 0; n_div = 0;
            if (!exp_to) exp_to = 1'b0;
            exp_to = 1'b0;
        end else if (is_div) begin
            n_div++;
        end else begin
            n_mul++;
        end
        tick();
        mul_ready = 1'b0; div_ready = 1'b0;
        mul_wr = 1'b0; div_wr = 1'b0;
        stat_clr = 1'b0;
        pcpi_valid = 1'b0;
        cfg_mul_en = 1'b1;
        cfg_div_en = 1'b1;
        #1;
        n_tests++;
        if (pcpi_wait !== 1'b0 || mul_valid !== 1'b0 || div_valid !== 1'b0 ||
            pcpi_ready !== 1'b0 || pcpi_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL op_done: wait=%b mv=%b dv=%b rdy=%b rd=%h, need all 0",
                     pcpi_wait, mul_valid, div_valid, pcpi_ready, pcpi_rd);
        end
        n_tests++;
        if (stat_mul_cnt !== CW'(sat(n_mul)) || stat_div_cnt !== CW'(sat(n_div)) ||
            stat_timeout !== exp_to) begin
            n_fail++;
            $display("FAIL op_counts: mul=%0d div=%0d to=%b, need %0d/%0d/%b",
                     stat_mul_cnt, stat_div_cnt, stat_timeout,
                     sat(n_mul), sat(n_div), exp_to);
        end
        tick();
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (pcpi_wait !== 0 || pcpi_ready !== 0 || pcpi_wr !== 0 ||
            pcpi_rd !== 0 || mul_valid !== 0 || div_valid !== 0 ||
            stat_mul_cnt !== 0 || stat_div_cnt !== 0 || stat_timeout !== 0) begin
            n_fail++;
            $display("FAIL reset: wait=%b rdy=%b mv=%b dv=%b cnt=%0d/%0d to=%b, need all 0",
                     pcpi_wait, pcpi_ready, mul_valid, div_valid,
                     stat_mul_cnt, stat_div_cnt, stat_timeout);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_mul_basic();
        run_op(1'b0, 4, 32'h12345678, 1'b1, 1'b0);
    endtask

    task automatic test_div_enable();
        cfg_div_en = 1'b0;
        pcpi_insn  = mk_insn(1'b1);
        pcpi_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_tests++;
            if (div_valid !== 0 || mul_valid !== 0 || pcpi_wait !== 0 ||
                stat_div_cnt !== CW'(sat(n_div))) begin
                n_fail++;
                $display("FAIL div_disabled c=%0d: dv=%b mv=%b wait=%b cnt=%0d, need 0/0/0/%0d",
                         i, div_valid, mul_valid, pcpi_wait, stat_div_cnt, sat(n_div));
            end
            tick();
        end
        pcpi_valid = 1'b0;
        tick();
        run_op(1'b1, $urandom_range(1, 7), $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_non_m();
        for (int i = 0; i < 12; i++) begin
            pcpi_insn = $urandom;
            if (i < 8) pcpi_insn[31:25] = 7'b0000000;
            else       pcpi_insn[6:0] = 7'b0110111;
            if (i < 8) pcpi_insn[6:0] = 7'b0110011;
            else       pcpi_insn[31:25] = 7'b0000001;
            pcpi_valid = 1'b1;
            #1;
            n_tests++;
            if (mul_valid !== 0 || div_valid !== 0 || pcpi_wait !== 0 ||
                pcpi_ready !== 0) begin
                n_fail++;
                $display("FAIL non_m i=%0d: mv=%b dv=%b wait=%b rdy=%b, need 0",
                         i, mul_valid, div_valid, pcpi_wait, pcpi_ready);
            end
            tick();
        end
        pcpi_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        pcpi_insn  = mk_insn(1'b1);
        pcpi_valid = 1'b1;
        tick();
        for (int g = 0; g < TO; g++) begin
            // Clear coincident with the timeout: the set must win.
            stat_clr = (g == TO - 1);
            #1;
            n_tests++;
            if (pcpi_wait !== 1 || div_valid !== 1) begin
                n_fail++;
                $display("FAIL to_grant g=%0d: wait=%b dv=%b, need 1/1",
                         g, pcpi_wait, div_valid);
            end
            tick();
        end
        stat_clr = 1'b0;
        n_mul = 0; n_div = 0; exp_to = 1'b1;
        div_ready = 1'b1; div_wr = 1'b1; div_rd = $urandom;
        #1;
        n_tests++;
        if (pcpi_wait !== 0 || div_valid !== 0 || stat_timeout !== 1 ||
            pcpi_ready !== 0 || pcpi_rd !== 0 || stat_div_cnt !== 0) begin
            n_fail++;
            $display("FAIL to_abort: wait=%b dv=%b to=%b rdy=%b rd=%h cnt=%0d, need 0/0/1/0/0/0",
                     pcpi_wait, div_valid, stat_timeout, pcpi_ready, pcpi_rd, stat_div_cnt);
        end
        tick();
        #1;
        n_tests++;
        if (pcpi_wait !== 0 || pcpi_ready !== 0 || stat_div_cnt !== 0) begin
            n_fail++;
            $display("FAIL to_hold: wait=%b rdy=%b cnt=%0d, need 0/0/0",
                     pcpi_wait, pcpi_ready, stat_div_cnt);
        end
        div_ready = 1'b0; div_wr = 1'b0;
        pcpi_valid = 1'b0;
        tick();
        run_op(1'b0, $urandom_range(1, 7), $urandom, 1'b1, 1'b0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_mul = 0; n_div = 0; exp_to = 1'b0;
        #1;
        n_tests++;
        if (stat_timeout !== 0 || stat_mul_cnt !== 0) begin
            n_fail++;
            $display("FAIL to_clear: to=%b cnt=%0d, need 0/0", stat_timeout, stat_mul_cnt);
        end
        tick();
    endtask

    task automatic test_flush_reset();
        pcpi_insn  = mk_insn(1'b0);
        pcpi_valid = 1'b1;
        tick();
        tick();
        tick();
        pcpi_valid = 1'b0;
        #1;
        n_tests++;
        if (mul_valid !== 0 || pcpi_wait !== 1) begin
            n_fail++;
            $display("FAIL flush_drop: mv=%b wait=%b, need 0/1", mul_valid, pcpi_wait);
        end
        tick();
        n_tests++;
        if (pcpi_wait !== 0 || stat_mul_cnt !== CW'(sat(n_mul))) begin
            n_fail++;
            $display("FAIL flush_idle: wait=%b cnt=%0d, need 0/%0d",
                     pcpi_wait, stat_mul_cnt, sat(n_mul));
        end
        run_op(1'b0, 2, $urandom, 1'b1, 1'b0);
        pcpi_insn  = mk_insn(1'b1);
        pcpi_valid = 1'b1;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        n_mul = 0; n_div = 0; exp_to = 1'b0;
        n_tests++;
        if (div_valid !== 0 || mul_valid !== 0 || pcpi_wait !== 0 ||
            stat_mul_cnt !== 0 || stat_div_cnt !== 0 || stat_timeout !== 0) begin
            n_fail++;
            $display("FAIL async_reset: dv=%b mv=%b wait=%b cnt=%0d/%0d to=%b, need 0",
                     div_valid, mul_valid, pcpi_wait, stat_mul_cnt, stat_div_cnt,
                     stat_timeout);
        end
        tick();
        pcpi_valid = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_saturate_clr();
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, $urandom_range(1, 7), $urandom, 1'($urandom), 1'b0);
        end
        n_tests++;
        if (stat_mul_cnt !== CW'(CMAX)) begin
            n_fail++;
            $display("FAIL sat_hold: cnt=%0d, need %0d", stat_mul_cnt, CMAX);
        end
        run_op(1'b0, $urandom_range(1, 7), $urandom, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 14; i++) begin
            run_op(1'($urandom), $urandom_range(1, 7), $urandom, 1'($urandom),
                   ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_div_enable();
        test_non_m();
        test_timeout();
        test_flush_reset();
        test_saturate_clr();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, need completion");
        $fatal(1, "watchdog");
    end

endmodule
